// File: rtl/heap_interval_guard_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | heap_interval_guard_if: issue/crash/debug bundle of the guard      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface heap_interval_guard_if #(
  parameter int ADDR_W    = 32,
  parameter int BUF_DEPTH = 8
);
  localparam int IDX_W = $clog2(BUF_DEPTH);

  logic              flush_i;
  logic              clr_buf_i;
  logic              valid_i;
  logic [1:0]        kind_i;
  logic [1:0]        size_i;
  logic [4:0]        rs1_i;
  logic [ADDR_W-1:0] addr_i;
  logic              en_check_i;
  logic              crash_o;
  logic              crash_seen_o;
  logic [IDX_W:0]    count_o;
  logic [IDX_W-1:0]  rd_idx_i;
  logic [ADDR_W-1:0] rd_first_o;
  logic [ADDR_W-1:0] rd_last_o;

  modport master (
    output flush_i, clr_buf_i, valid_i, kind_i, size_i, rs1_i, addr_i, en_check_i, rd_idx_i,
    input  crash_o, crash_seen_o, count_o, rd_first_o, rd_last_o
  );

  modport slave (
    input  flush_i, clr_buf_i, valid_i, kind_i, size_i, rs1_i, addr_i, en_check_i, rd_idx_i,
    output crash_o, crash_seen_o, count_o, rd_first_o, rd_last_o
  );
endinterface
`default_nettype wire

// File: rtl/heap_interval_guard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | heap_interval_guard: store-run tracking, range buffer, jump kill   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module heap_interval_guard #(
  parameter int NR_TRACKERS = 2,
  parameter int BUF_DEPTH   = 8,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT     = 10,
  parameter int MIN_LEN     = 32
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  heap_interval_guard_if.slave bus
);
  localparam int                IDX_W     = $clog2(BUF_DEPTH);
  localparam int                CNT_W     = IDX_W + 1;
  localparam logic [1:0]        KIND_LOAD = 2'd1;
  localparam logic [1:0]        KIND_ST   = 2'd2;
  localparam logic [1:0]        KIND_JUMP = 2'd3;
  localparam logic [4:0]        SP_REG    = 5'd2;
  localparam logic [3:0]        TMR_INIT  = 4'(TIMEOUT);
  localparam logic [ADDR_W-1:0] MIN_LEN_V = ADDR_W'(MIN_LEN);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BUF_DEPTH);

  logic [NR_TRACKERS-1:0] act_q, act_d;
  logic [ADDR_W-1:0]      first_q [NR_TRACKERS];
  logic [ADDR_W-1:0]      first_d [NR_TRACKERS];
  logic [ADDR_W-1:0]      last_q  [NR_TRACKERS];
  logic [ADDR_W-1:0]      last_d  [NR_TRACKERS];
  logic [3:0]             tmr_q   [NR_TRACKERS];
  logic [3:0]             tmr_d   [NR_TRACKERS];

  logic [ADDR_W-1:0]      bfirst_q [BUF_DEPTH];
  logic [ADDR_W-1:0]      blast_q  [BUF_DEPTH];
  logic [IDX_W-1:0]       wr_ptr_q;
  logic [CNT_W-1:0]       count_q;

  logic flag_q, flag_d, crash_q, crash_d, seen_q;

  logic                   is_store, hit, ext_hit, alloc_hit, ev_any;
  logic [ADDR_W:0]        step;
  logic [NR_TRACKERS-1:0] ev_sel;
  logic [3:0]             ev_tmr;
  logic                   commit;
  logic [ADDR_W-1:0]      cm_first, cm_last;

  always_comb begin
    act_d     = act_q;
    first_d   = first_q;
    last_d    = last_q;
    tmr_d     = tmr_q;
    flag_d    = flag_q;
    crash_d   = 1'b0;
    commit    = 1'b0;
    cm_first  = '0;
    cm_last   = '0;
    hit       = 1'b0;
    ext_hit   = 1'b0;
    alloc_hit = 1'b0;
    ev_any    = 1'b0;
    ev_sel    = '0;
    ev_tmr    = '0;
    is_store  = (bus.kind_i == KIND_ST) && (bus.rs1_i != SP_REG);
    step      = {{ADDR_W{1'b0}}, 1'b1} << bus.size_i;

    // Load hit is judged against the state before this cycle's update
    for (int i = 0; i < BUF_DEPTH; i++)
      if (CNT_W'(i) < count_q && bus.addr_i >= bfirst_q[i] && bus.addr_i <= blast_q[i])
        hit = 1'b1;
    for (int t = 0; t < NR_TRACKERS; t++)
      if (act_q[t] && bus.addr_i >= first_q[t] && bus.addr_i <= last_q[t])
        hit = 1'b1;

    for (int t = 0; t < NR_TRACKERS; t++)
      if (!ev_any || tmr_q[t] < ev_tmr) begin
        ev_any    = 1'b1;
        ev_tmr    = tmr_q[t];
        ev_sel    = '0;
        ev_sel[t] = 1'b1;
      end

    if (bus.flush_i) begin
      act_d  = '0;
      flag_d = 1'b0;
      for (int t = 0; t < NR_TRACKERS; t++) tmr_d[t] = '0;
    end else if (bus.valid_i) begin
      if (is_store) begin
        for (int t = 0; t < NR_TRACKERS; t++)
          if (!ext_hit && act_q[t] && ({1'b0, last_q[t]} + step == {1'b0, bus.addr_i})) begin
            ext_hit   = 1'b1;
            last_d[t] = bus.addr_i;
            tmr_d[t]  = TMR_INIT;
          end
        for (int t = 0; t < NR_TRACKERS; t++)
          if (!ext_hit && !alloc_hit && !act_q[t]) begin
            alloc_hit  = 1'b1;
            act_d[t]   = 1'b1;
            first_d[t] = bus.addr_i;
            last_d[t]  = bus.addr_i;
            tmr_d[t]   = TMR_INIT;
          end
        for (int t = 0; t < NR_TRACKERS; t++)
          if (!ext_hit && !alloc_hit && ev_sel[t]) begin
            commit     = (last_q[t] - first_q[t]) >= MIN_LEN_V;
            cm_first   = first_q[t];
            cm_last    = last_q[t];
            first_d[t] = bus.addr_i;
            last_d[t]  = bus.addr_i;
            tmr_d[t]   = TMR_INIT;
          end
      end else begin
        // Short runs retire freely; long ones queue for the single commit slot
        for (int t = 0; t < NR_TRACKERS; t++)
          if (act_q[t]) begin
            if (tmr_q[t] != 4'd0) begin
              tmr_d[t] = tmr_q[t] - 4'd1;
            end else if ((last_q[t] - first_q[t]) < MIN_LEN_V) begin
              act_d[t] = 1'b0;
            end else if (!commit) begin
              act_d[t] = 1'b0;
              commit   = 1'b1;
              cm_first = first_q[t];
              cm_last  = last_q[t];
            end
          end
        if (bus.kind_i == KIND_LOAD) flag_d = hit;
        if (bus.kind_i == KIND_JUMP) crash_d = flag_q && bus.en_check_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      act_q <= '0;
      for (int t = 0; t < NR_TRACKERS; t++) begin
        first_q[t] <= '0;
        last_q[t]  <= '0;
        tmr_q[t]   <= '0;
      end
      for (int i = 0; i < BUF_DEPTH; i++) begin
        bfirst_q[i] <= '0;
        blast_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      crash_q  <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      act_q   <= act_d;
      first_q <= first_d;
      last_q  <= last_d;
      tmr_q   <= tmr_d;
      flag_q  <= flag_d;
      crash_q <= crash_d;
      seen_q  <= seen_q | crash_d;
      if (bus.clr_buf_i) begin
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else if (commit) begin
        bfirst_q[wr_ptr_q] <= cm_first;
        blast_q[wr_ptr_q]  <= cm_last;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
        if (count_q != CNT_FULL) count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.crash_o      = crash_q;
  assign bus.crash_seen_o = seen_q;
  assign bus.count_o      = count_q;
  assign bus.rd_first_o   = bfirst_q[bus.rd_idx_i];
  assign bus.rd_last_o    = blast_q[bus.rd_idx_i];

endmodule
`default_nettype wire
